cpu_seq: RTL and testbench

- Multi-cycle sequencer for the CPU datapath: instruction fetch, decode, execute, optional memory access, writeback.
- Owns the PC and the instruction register feeding the control unit.
- Gates the control unit's register-file write and branch-unit decisions so each takes effect in exactly one cycle per instruction.
- Handles req/ack handshakes to instruction and data memory with a timeout, and halts on illegal opcodes or faults.

---
 rtl/cpu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// access and writeback. Owns the PC and instruction register, gates the
// control unit's register-file write to the writeback cycle, and halts with
// a sticky fault code on illegal opcodes, memory timeouts or misaligned
// branch/jump targets.
module cpu_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_lsu_active,
  output logic        o_dmem_req,
  input  logic        i_dmem_ack,
  input  logic        i_regfile_we,
  output logic        o_regfile_we,
  input  logic        i_bu_taken,
  input  logic [31:0] i_alu_result,
  output logic        o_retire,
  output logic [31:0] o_retire_cnt,
  output logic        o_halt,
  output logic [2:0]  o_fault
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    F_NONE     = 3'd0,
    F_ILLEGAL  = 3'd1,
    F_IMEM_TO  = 3'd2,
    F_DMEM_TO  = 3'd3,
    F_MISALIGN = 3'd4
  } fault_e;

  // Opcodes the datapath implements; anything else (MSCMEM, SYSTEM, ...)
  // is treated as illegal.
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Last wait count that may still see an ack; a wait of TIMEOUT-1 cycles
  // (ack in the TIMEOUT-th cycle of the state) is accepted.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [2:0]  fault_q, fault_d;

  logic        imem_req, dmem_req, regfile_we, retire;
  logic        opcode_legal;
  logic [31:0] target;
  logic        misaligned;

  // Branch/jump target with bit0 cleared; bit1 set means not word aligned.
  assign target     = i_alu_result & ~32'h0000_0001;
  assign misaligned = i_bu_taken & target[1];

  // Opcode legality decode of the latched instruction.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    opcode_legal = 1'b0;
    case (inst_q[6:0])
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  end

  // Next-state and output decode; the wait counter defaults to zero so it
  // clears on every state entry and only counts while waiting for an ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    cnt_d        = '0;
    retire_cnt_d = retire_cnt_q;
    fault_d      = fault_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    regfile_we   = 1'b0;
    retire       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (i_imem_ack) begin
          inst_d  = i_imem_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = F_IMEM_TO;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DECODE: begin
        if (!opcode_legal) begin
          fault_d = F_ILLEGAL;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = i_lsu_active ? S_MEM : S_WB;
      end

      S_MEM: begin
        dmem_req = 1'b1;
        if (i_dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = F_DMEM_TO;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WB: begin
        if (misaligned) begin
          // The faulting instruction has no architectural effect.
          fault_d = F_MISALIGN;
          state_d = S_HALT;
        end else begin
          regfile_we   = i_regfile_we;
          retire       = 1'b1;
          retire_cnt_d = retire_cnt_q + 32'd1;
          pc_d         = i_bu_taken ? target : pc_q + 32'd4;
          state_d      = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      cnt_q        <= '0;
      retire_cnt_q <= '0;
      fault_q      <= F_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      cnt_q        <= cnt_d;
      retire_cnt_q <= retire_cnt_d;
      fault_q      <= fault_d;
    end
  end

  // Requests, write enable and retire drop in the reset cycle itself so an
  // in-flight memory request is withdrawn immediately.
  assign o_imem_req   = imem_req   & i_rst_n;
  assign o_dmem_req   = dmem_req   & i_rst_n;
  assign o_regfile_we = regfile_we & i_rst_n;
  assign o_retire     = retire     & i_rst_n;

  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_inst       = inst_q;
  assign o_retire_cnt = retire_cnt_q;
  assign o_halt       = (state_q == S_HALT);
  assign o_fault      = fault_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: the bench plays instruction and data
// memory with programmable ack delays, pushes the expected outcome of each
// instruction to a scoreboard and compares when the DUT retires it.
module tb_cpu_seq;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_LW     = 32'h0000_a103;
  localparam logic [31:0] I_SW     = 32'h0020_a223;
  localparam logic [31:0] I_JAL    = 32'h0080_00ef;
  localparam logic [31:0] I_BEQ    = 32'h0000_0063;
  localparam logic [31:0] I_ADD    = 32'h0020_81b3;
  localparam logic [31:0] I_SYSTEM = 32'h0000_0073;
  localparam logic [31:0] I_FENCE  = 32'h0000_000f;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic [31:0] imem_addr, imem_rdata, inst, pc, alu_result, retire_cnt;
  logic        lsu_active, rf_we_in, rf_we_out, bu_taken, retire, halt;
  logic [2:0]  fault;

  always #5 clk = ~clk;

  cpu_seq #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT),
    .NOP_INST(NOP_INST)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_imem_req  (imem_req),
    .o_imem_addr (imem_addr),
    .i_imem_ack  (imem_ack),
    .i_imem_rdata(imem_rdata),
    .o_inst      (inst),
    .o_pc        (pc),
    .i_lsu_active(lsu_active),
    .o_dmem_req  (dmem_req),
    .i_dmem_ack  (dmem_ack),
    .i_regfile_we(rf_we_in),
    .o_regfile_we(rf_we_out),
    .i_bu_taken  (bu_taken),
    .i_alu_result(alu_result),
    .o_retire    (retire),
    .o_retire_cnt(retire_cnt),
    .o_halt      (halt),
    .o_fault     (fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    int          cycles;
    int          we_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = 32'h0;
    lsu_active = 1'b0;
    rf_we_in   = 1'b1;
    bu_taken   = 1'b0;
    alu_result = 32'h0;
  endtask

  // Hold reset for two cycles, check reset values, release and check that
  // the first fetch request rises immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_rf_we", rf_we_out, 1'b0);
    check("rst_retire", retire, 1'b0);
    tick();
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, NOP_INST);
    check("rst_retire_cnt", retire_cnt, 32'd0);
    check("rst_fault", fault, 3'd0);
    check("rst_halt", halt, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_imem_req", imem_req, 1'b1);
    m_pc  = RESET_PC;
    m_cnt = 32'd0;
    sb.delete();
  endtask

  // Run one instruction acting as both memories. iw/dw are the wait cycles
  // before ack (-1 = never ack). stray drives the other memory's ack high
  // whenever it is not being requested. exp_fault=0 expects retirement,
  // otherwise a halt with that fault code in cycle exp_halt.
  task automatic run_inst(input logic [31:0] ins, input int iw, input bit lsu,
                          input int dw, input bit we, input bit taken,
                          input logic [31:0] alu, input bit stray,
                          input logic [2:0] exp_fault, input int exp_halt);
    exp_t        e;
    int          cyc = 0, iwc = 0, dwc = 0;
    int          we_n = 0, we_cyc = 0, ret_n = 0, ireq_n = 0, dreq_n = 0;
    int          halt_cyc = -1;
    bit          done = 1'b0;
    logic [31:0] wb_inst = 32'h0;
    logic [31:0] start_pc = m_pc;

    if (exp_fault == 3'd0) begin
      e.cycles = 4 + iw + (lsu ? 1 + dw : 0);
      e.pc     = taken ? {alu[31:1], 1'b0} : m_pc + 32'd4;
      e.cnt    = m_cnt + 32'd1;
      e.we_n   = we ? 1 : 0;
      sb.push_back(e);
    end

    imem_rdata = ins;
    lsu_active = lsu;
    rf_we_in   = we;
    bu_taken   = taken;
    alu_result = alu;
    check("fetch_addr", imem_addr, m_pc);

    while (!done && cyc < 60) begin
      cyc++;
      if (halt) begin
        halt_cyc = cyc;
        done     = 1'b1;
      end else begin
        imem_ack = imem_req ? (iw >= 0 && iwc == iw) : stray;
        if (imem_req && !imem_ack) iwc++;
        dmem_ack = dmem_req ? (dw >= 0 && dwc == dw) : stray;
        if (dmem_req && !dmem_ack) dwc++;
        if (imem_req) ireq_n++;
        if (dmem_req) dreq_n++;
        #1;
        if (rf_we_out) begin
          we_n++;
          we_cyc = cyc;
        end
        if (retire) begin
          ret_n++;
          wb_inst = inst;
          done    = 1'b1;
        end
        tick();
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    if (exp_fault == 3'd0) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("retire_seen", ret_n, 32'd1);
        check("cycles", cyc, e.cycles);
        check("rf_we_count", we_n, e.we_n);
        if (e.we_n != 0) check("rf_we_cycle", we_cyc, e.cycles);
        check("imem_req_cycles", ireq_n, iw + 1);
        check("dmem_req_cycles", dreq_n, lsu ? dw + 1 : 0);
        check("wb_inst", wb_inst, ins);
        check("pc", pc, e.pc);
        check("retire_cnt", retire_cnt, e.cnt);
        check("fault_none", fault, 3'd0);
        check("next_fetch_req", imem_req, 1'b1);
        m_pc  = e.pc;
        m_cnt = e.cnt;
      end
    end else begin
      check("halt_cycle", halt_cyc, exp_halt);
      check("fault_code", fault, exp_fault);
      check("fault_rf_we", we_n, 32'd0);
      check("fault_retire", ret_n, 32'd0);
      check("fault_pc", pc, start_pc);
      check("fault_retire_cnt", retire_cnt, m_cnt);
      // Halted: stray acks must not wake anything up.
      ireq_n = 0;
      dreq_n = 0;
      we_n   = 0;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (imem_req) ireq_n++;
        if (dmem_req) dreq_n++;
        if (rf_we_out) we_n++;
        tick();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      check("halt_imem_req", ireq_n, 32'd0);
      check("halt_dmem_req", dreq_n, 32'd0);
      check("halt_rf_we", we_n, 32'd0);
      check("halt_sticky", halt, 1'b1);
      check("fault_held", fault, exp_fault);
    end
  endtask

  // Reset while the data access is waiting for an ack.
  task automatic reset_in_mem();
    int cyc = 0;
    imem_rdata = I_LW;
    lsu_active = 1'b1;
    rf_we_in   = 1'b1;
    bu_taken   = 1'b0;
    while (!dmem_req && cyc < 20) begin
      imem_ack = imem_req;
      cyc++;
      tick();
    end
    imem_ack = 1'b0;
    check("reached_mem", dmem_req, 1'b1);
    tick();
    tick();
    check("mem_still_waiting", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_dmem_req", dmem_req, 1'b0);
    tick();
    check("rst_mem_dmem_req_next", dmem_req, 1'b0);
    check("rst_mem_pc", pc, RESET_PC);
    check("rst_mem_retire_cnt", retire_cnt, 32'd0);
    check("rst_mem_inst", inst, NOP_INST);
    rst_n = 1'b1;
    #1;
    check("rst_mem_fetch_req", imem_req, 1'b1);
    check("rst_mem_fetch_addr", imem_addr, RESET_PC);
    check("rst_mem_no_dreq", dmem_req, 1'b0);
    m_pc  = RESET_PC;
    m_cnt = 32'd0;
  endtask

  initial begin
    do_reset();
    // ins, iw, lsu, dw, we, taken, alu, stray, fault, halt_cyc
    run_inst(I_ADDI, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 0);
    run_inst(I_LW,   0, 1'b1, 3, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 0);
    run_inst(I_SW,   2, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 0);
    run_inst(I_JAL,  0, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0101, 1'b0, 3'd0, 0);
    run_inst(I_BEQ,  1, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 3'd0, 0);
    run_inst(I_ADD,  TIMEOUT - 1, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 0);
    run_inst(I_LW,   0, 1'b1, TIMEOUT - 1, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0, 0);
    run_inst(I_BEQ,  0, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 3'd4, 5);

    do_reset();
    run_inst(I_SYSTEM, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd1, 3);
    do_reset();
    run_inst(I_FENCE, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd1, 3);
    do_reset();
    run_inst(I_ADDI, -1, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd2, TIMEOUT + 1);
    do_reset();
    run_inst(I_LW, 0, 1'b1, -1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd3, TIMEOUT + 4);

    do_reset();
    run_inst(I_ADDI, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 0);
    reset_in_mem();
    run_inst(I_ADDI, 0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
